// File: rtl/lynx_bankctl.sv
// lynx_bankctl: paging controller for the Lynx memory map.
// Holds the bank-select and mode registers, decodes per-bank/ROM/video
// strobes with a one-hot read-data select, and arbitrates CPU video
// accesses against CRTC fetches with a bounded WAIT handshake.
module lynx_bankctl #(
    parameter int NB    = 4,
    parameter int NV    = 3,
    parameter int ROMPG = 3,
    parameter int WMAX  = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ce,
    input  logic          iorq,
    input  logic          mreq,
    input  logic          rd,
    input  logic          wr,
    input  logic [15:0]   a,
    input  logic [7:0]    q,
    input  logic          vreq,
    output logic [NB-1:0] bankR,
    output logic [NB-1:0] bankW,
    output logic          romR,
    output logic [NV-1:0] vplW,
    output logic          vplR,
    output logic [NB+1:0] dsel,
    output logic          wait_n,
    output logic          vgrant
);

    localparam int WW = $clog2(WMAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_VFETCH,
        S_CPU_WAIT,
        S_CPU_ACC
    } state_t;

    logic [7:0]    rsel_q, rsel_d;
    logic [7:0]    wsel_q, wsel_d;
    logic [7:0]    vmode_q, vmode_d;
    state_t        state_q, state_d;
    logic          vcnt_q, vcnt_d;
    logic          pend_q, pend_d;
    logic [WW-1:0] wcnt_q, wcnt_d;

    logic          rd_c, wr_c, vrd_c, vwr_c, cpu_vid, acc, stall, wsat;
    logic [WW-1:0] wnext;
    logic          unused_ok;

    // Register file and FSM state; reset returns everything to idle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rsel_q  <= 8'h00;
            wsel_q  <= 8'h01;
            vmode_q <= 8'h00;
            state_q <= S_IDLE;
            vcnt_q  <= 1'b0;
            pend_q  <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            rsel_q  <= rsel_d;
            wsel_q  <= wsel_d;
            vmode_q <= vmode_d;
            state_q <= state_d;
            vcnt_q  <= vcnt_d;
            pend_q  <= pend_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // I/O register writes, only on a CPU clock-enable
    always_comb begin
        rsel_d  = rsel_q;
        wsel_d  = wsel_q;
        vmode_d = vmode_q;
        if (ce && !iorq && !wr) begin
            case (a[7:0])
                8'h82:   rsel_d  = q;
                8'h83:   wsel_d  = q;
                8'h80:   vmode_d = q;
                default: ;
            endcase
        end
    end

    // Bus decode; video strobes are only released while the CPU owns the planes
    assign rd_c    = !mreq && !rd;
    assign wr_c    = !mreq && !wr;
    assign vrd_c   = rd_c && rsel_q[7];
    assign vwr_c   = wr_c && (|vmode_q[NV-1:0]);
    assign cpu_vid = vrd_c || vwr_c;
    assign acc     = (state_q == S_CPU_ACC);

    assign bankR = {NB{rd_c}} & rsel_q[NB-1:0];
    assign bankW = {NB{wr_c}} & wsel_q[NB-1:0];
    assign romR  = rd_c && !vmode_q[7] && (int'(a[15:13]) < ROMPG);
    assign vplR  = vrd_c && acc;
    assign vplW  = {NV{wr_c && acc}} & vmode_q[NV-1:0];

    // Read-data select: video over ROM over the lowest-numbered enabled bank
    always_comb begin
        logic found;
        dsel  = '0;
        found = 1'b0;
        if (vplR) begin
            dsel[NB+1] = 1'b1;
        end else if (romR) begin
            dsel[NB] = 1'b1;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (bankR[i] && !found) begin
                    dsel[i] = 1'b1;
                    found   = 1'b1;
                end
            end
        end
    end

    // The wait counter only runs while the CPU is being held off
    assign stall  = ((state_q == S_VFETCH) && cpu_vid) || (state_q == S_CPU_WAIT);
    assign wait_n = !stall;
    assign vgrant = (state_q == S_VFETCH);
    assign wnext  = (wcnt_q == WW'(WMAX)) ? wcnt_q : wcnt_q + 1'b1;
    assign wsat   = stall && (wnext == WW'(WMAX));

    // Arbitration: video fetch has priority unless the CPU stall budget runs out
    always_comb begin
        state_d = state_q;
        vcnt_d  = vcnt_q;
        pend_d  = pend_q;
        wcnt_d  = wcnt_q;
        if (ce) begin
            wcnt_d = stall ? wnext : '0;
            case (state_q)
                S_IDLE: begin
                    vcnt_d = 1'b0;
                    if (vreq)         state_d = S_VFETCH;
                    else if (cpu_vid) state_d = S_CPU_ACC;
                end
                S_VFETCH: begin
                    if (wsat) begin
                        vcnt_d  = 1'b0;
                        state_d = S_CPU_ACC;
                    end else if (vcnt_q) begin
                        vcnt_d  = 1'b0;
                        state_d = cpu_vid ? S_CPU_WAIT : S_IDLE;
                    end else begin
                        vcnt_d = 1'b1;
                    end
                end
                S_CPU_WAIT: state_d = S_CPU_ACC;
                S_CPU_ACC: begin
                    // one pending fetch slot; further requests are dropped
                    if (vreq) pend_d = 1'b1;
                    if (mreq) begin
                        state_d = (pend_q || vreq) ? S_VFETCH : S_IDLE;
                        pend_d  = 1'b0;
                        vcnt_d  = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign unused_ok = ^{a[12:8], rsel_q, wsel_q, vmode_q};

endmodule

// File: tb/tb_lynx_bankctl.sv
// Bench for lynx_bankctl: table of single-cycle vectors plus hand-written
// arbitration sequences; expectations go through a scoreboard queue that is
// drained on the falling clock edge. A second instance with WMAX=2 shares
// the stimulus for the stall-budget case.
module tb_lynx_bankctl;

    typedef struct packed {
        logic [3:0] br;
        logic [3:0] bw;
        logic       rr;
        logic [2:0] vw;
        logic       vr;
        logic [5:0] ds;
        logic       wn;
        logic       vg;
    } out_t;

    typedef struct {
        string name;
        bit    d2;
        out_t  exp;
    } sb_t;

    typedef struct {
        string       name;
        bit          cc;
        int          kind;
        logic [15:0] aa;
        logic [7:0]  qq;
        out_t        exp;
    } vec_t;

    localparam int BI = 0, MRD = 1, MWR = 2, IOW = 3, IORD = 4, MRW = 5;

    logic clock = 1'b0;
    logic reset, ce, iorq, mreq, rd, wr, vreq;
    logic [15:0] a;
    logic [7:0]  q;

    logic [3:0] bankR1, bankW1, bankR2, bankW2;
    logic       romR1, romR2, vplR1, vplR2, wait_n1, wait_n2, vgrant1, vgrant2;
    logic [2:0] vplW1, vplW2;
    logic [5:0] dsel1, dsel2;
    out_t       o1, o2;

    int   n_checks = 0;
    int   n_errors = 0;
    sb_t  sb[$];
    vec_t tbl[$];

    always #5 clock = ~clock;

    lynx_bankctl #(.NB(4), .NV(3), .ROMPG(3), .WMAX(4)) dut (
        .clock(clock), .reset(reset), .ce(ce), .iorq(iorq), .mreq(mreq),
        .rd(rd), .wr(wr), .a(a), .q(q), .vreq(vreq),
        .bankR(bankR1), .bankW(bankW1), .romR(romR1), .vplW(vplW1),
        .vplR(vplR1), .dsel(dsel1), .wait_n(wait_n1), .vgrant(vgrant1)
    );

    lynx_bankctl #(.NB(4), .NV(3), .ROMPG(3), .WMAX(2)) dut2 (
        .clock(clock), .reset(reset), .ce(ce), .iorq(iorq), .mreq(mreq),
        .rd(rd), .wr(wr), .a(a), .q(q), .vreq(vreq),
        .bankR(bankR2), .bankW(bankW2), .romR(romR2), .vplW(vplW2),
        .vplR(vplR2), .dsel(dsel2), .wait_n(wait_n2), .vgrant(vgrant2)
    );

    assign o1 = {bankR1, bankW1, romR1, vplW1, vplR1, dsel1, wait_n1, vgrant1};
    assign o2 = {bankR2, bankW2, romR2, vplW2, vplR2, dsel2, wait_n2, vgrant2};

    function automatic out_t mk(logic [3:0] br, logic [3:0] bw, logic rr,
                                logic [2:0] vw, logic vr, logic [5:0] ds,
                                logic wn, logic vg);
        out_t o;
        o = '{br: br, bw: bw, rr: rr, vw: vw, vr: vr, ds: ds, wn: wn, vg: vg};
        return o;
    endfunction

    task automatic drain();
        sb_t  e;
        out_t act;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            act = e.d2 ? o2 : o1;
            n_checks++;
            if (act !== e.exp) begin
                n_errors++;
                $display("FAIL %s%s: got br=%b bw=%b rom=%b vw=%b vr=%b ds=%b wn=%b vg=%b, want br=%b bw=%b rom=%b vw=%b vr=%b ds=%b wn=%b vg=%b",
                         e.name, e.d2 ? "(wmax2)" : "",
                         act.br, act.bw, act.rr, act.vw, act.vr, act.ds, act.wn, act.vg,
                         e.exp.br, e.exp.bw, e.exp.rr, e.exp.vw, e.exp.vr, e.exp.ds, e.exp.wn, e.exp.vg);
            end
        end
    endtask

    always @(negedge clock) drain();

    task automatic drive(int kind, logic [15:0] aa, logic [7:0] qq, bit vr, bit cc);
        {iorq, mreq, rd, wr} = 4'b1111;
        case (kind)
            MRD:  {mreq, rd}     = 2'b00;
            MWR:  {mreq, wr}     = 2'b00;
            MRW:  {mreq, rd, wr} = 3'b000;
            IOW:  {iorq, wr}     = 2'b00;
            IORD: {iorq, rd}     = 2'b00;
            default: ;
        endcase
        a    = aa;
        q    = qq;
        vreq = vr;
        ce   = cc;
    endtask

    // one ce cycle: drive just after the rising edge, expectation checked at the falling edge
    task automatic step(string nm, int kind, logic [15:0] aa, logic [7:0] qq,
                        bit vr, out_t ex, bit cc = 1'b1);
        @(posedge clock);
        #1;
        drive(kind, aa, qq, vr, cc);
        sb.push_back('{name: nm, d2: 1'b0, exp: ex});
    endtask

    task automatic exp2(string nm, out_t ex);
        sb.push_back('{name: nm, d2: 1'b1, exp: ex});
    endtask

    task automatic addv(string nm, bit cc, int kind, logic [15:0] aa,
                        logic [7:0] qq, out_t ex);
        tbl.push_back('{name: nm, cc: cc, kind: kind, aa: aa, qq: qq, exp: ex});
    endtask

    initial begin
        out_t z;
        z = mk(4'b0, 4'b0, 0, 3'b0, 0, 6'b0, 1, 0);

        reset = 1'b0;
        drive(BI, 16'h0000, 8'h00, 1'b0, 1'b1);
        step("rst_hold", BI, 16'h0000, 8'h00, 0, z);
        exp2("rst_hold", z);
        @(negedge clock);
        #1 reset = 1'b1;

        addv("idle",       1, BI,   16'h0000, 8'h00, z);
        addv("rd_1000",    1, MRD,  16'h1000, 8'h00, mk(4'b0000, 4'b0000, 1, 3'b0, 0, 6'b010000, 1, 0));
        addv("rd_6000",    1, MRD,  16'h6000, 8'h00, z);
        addv("rd_8000_r0", 1, MRD,  16'h8000, 8'h00, z);
        addv("wr_8000_w1", 1, MWR,  16'h8000, 8'h00, mk(4'b0000, 4'b0001, 0, 3'b0, 0, 6'b0, 1, 0));
        addv("ioread_82",  1, IORD, 16'h0082, 8'h00, z);
        addv("out82_05",   1, IOW,  16'h0082, 8'h05, z);
        addv("rd_8000",    1, MRD,  16'h8000, 8'h00, mk(4'b0101, 4'b0000, 0, 3'b0, 0, 6'b000001, 1, 0));
        addv("out80_80",   1, IOW,  16'h0080, 8'h80, z);
        addv("rd_0000_nr", 1, MRD,  16'h0000, 8'h00, mk(4'b0101, 4'b0000, 0, 3'b0, 0, 6'b000001, 1, 0));
        addv("out83_06",   1, IOW,  16'h0083, 8'h06, z);
        addv("wr_4000",    1, MWR,  16'h4000, 8'h00, mk(4'b0000, 4'b0110, 0, 3'b0, 0, 6'b0, 1, 0));
        addv("out80_00",   1, IOW,  16'h0080, 8'h00, z);
        addv("rd_2000",    1, MRD,  16'h2000, 8'h00, mk(4'b0101, 4'b0000, 1, 3'b0, 0, 6'b010000, 1, 0));
        addv("rd_5fff",    1, MRD,  16'h5fff, 8'h00, mk(4'b0101, 4'b0000, 1, 3'b0, 0, 6'b010000, 1, 0));
        addv("out82_08",   1, IOW,  16'h0082, 8'h08, z);
        addv("out82_noce", 0, IOW,  16'h0082, 8'h01, z);
        addv("rd_a000",    1, MRD,  16'ha000, 8'h00, mk(4'b1000, 4'b0000, 0, 3'b0, 0, 6'b001000, 1, 0));
        addv("out82_80",   1, IOW,  16'h0082, 8'h80, z);
        addv("out80_07",   1, IOW,  16'h0080, 8'h07, z);

        foreach (tbl[i])
            step(tbl[i].name, tbl[i].kind, tbl[i].aa, tbl[i].qq, 0, tbl[i].exp, tbl[i].cc);

        // CPU plane write colliding with a fetch request in the same ce
        step("col_c0", MWR, 16'hc000, 8'h00, 1, mk(4'b0, 4'b0110, 0, 3'b000, 0, 6'b0, 1, 0));
        step("col_c1", MWR, 16'hc000, 8'h00, 0, mk(4'b0, 4'b0110, 0, 3'b000, 0, 6'b0, 0, 1));
        step("col_c2", MWR, 16'hc000, 8'h00, 0, mk(4'b0, 4'b0110, 0, 3'b000, 0, 6'b0, 0, 1));
        step("col_c3", MWR, 16'hc000, 8'h00, 0, mk(4'b0, 4'b0110, 0, 3'b000, 0, 6'b0, 0, 0));
        step("col_c4", MWR, 16'hc000, 8'h00, 0, mk(4'b0, 4'b0110, 0, 3'b111, 0, 6'b0, 1, 0));
        step("col_c5", BI,  16'h0000, 8'h00, 0, z);

        // fetch requests during a CPU video read are held and served once
        step("acc_d0", MRD, 16'hc000, 8'h00, 0, z);
        step("acc_d1", MRD, 16'hc000, 8'h00, 1, mk(4'b0, 4'b0, 0, 3'b0, 1, 6'b100000, 1, 0));
        step("acc_d2", MRD, 16'hc000, 8'h00, 0, mk(4'b0, 4'b0, 0, 3'b0, 1, 6'b100000, 1, 0));
        step("acc_d3", MRD, 16'hc000, 8'h00, 1, mk(4'b0, 4'b0, 0, 3'b0, 1, 6'b100000, 1, 0));
        step("acc_d4", BI,  16'h0000, 8'h00, 0, z);
        step("acc_d5", BI,  16'h0000, 8'h00, 0, mk(4'b0, 4'b0, 0, 3'b0, 0, 6'b0, 1, 1));
        step("acc_d6", BI,  16'h0000, 8'h00, 0, mk(4'b0, 4'b0, 0, 3'b0, 0, 6'b0, 1, 1));
        step("acc_d7", BI,  16'h0000, 8'h00, 0, z);
        step("acc_d8", BI,  16'h0000, 8'h00, 0, z);

        // CPU access appearing at fetch entry: WMAX=2 caps the stall at two cycles
        step("wm_e0", BI,  16'h0000, 8'h00, 1, z);
        exp2("wm_e0", z);
        step("wm_e1", MWR, 16'hc000, 8'h00, 0, mk(4'b0, 4'b0110, 0, 3'b000, 0, 6'b0, 0, 1));
        exp2("wm_e1", mk(4'b0, 4'b0110, 0, 3'b000, 0, 6'b0, 0, 1));
        step("wm_e2", MWR, 16'hc000, 8'h00, 0, mk(4'b0, 4'b0110, 0, 3'b000, 0, 6'b0, 0, 1));
        exp2("wm_e2", mk(4'b0, 4'b0110, 0, 3'b000, 0, 6'b0, 0, 1));
        step("wm_e3", MWR, 16'hc000, 8'h00, 0, mk(4'b0, 4'b0110, 0, 3'b000, 0, 6'b0, 0, 0));
        exp2("wm_e3", mk(4'b0, 4'b0110, 0, 3'b111, 0, 6'b0, 1, 0));
        step("wm_e4", MWR, 16'hc000, 8'h00, 0, mk(4'b0, 4'b0110, 0, 3'b111, 0, 6'b0, 1, 0));
        exp2("wm_e4", mk(4'b0, 4'b0110, 0, 3'b111, 0, 6'b0, 1, 0));
        step("wm_e5", BI,  16'h0000, 8'h00, 0, z);
        exp2("wm_e5", z);

        // reset pulled in the middle of CPU_WAIT
        step("out82_81", IOW, 16'h0082, 8'h81, 0, z);
        step("rs_f0", MWR, 16'hc000, 8'h00, 1, mk(4'b0, 4'b0110, 0, 3'b000, 0, 6'b0, 1, 0));
        step("rs_f1", MWR, 16'hc000, 8'h00, 0, mk(4'b0, 4'b0110, 0, 3'b000, 0, 6'b0, 0, 1));
        step("rs_f2", MWR, 16'hc000, 8'h00, 0, mk(4'b0, 4'b0110, 0, 3'b000, 0, 6'b0, 0, 1));
        step("rs_f3", MWR, 16'hc000, 8'h00, 0, mk(4'b0, 4'b0110, 0, 3'b000, 0, 6'b0, 0, 0));
        @(negedge clock);
        #1 reset = 1'b0;
        #1 drive(MRW, 16'h8000, 8'h00, 1'b0, 1'b1);
        #1 sb.push_back('{name: "rs_async", d2: 1'b0, exp: mk(4'b0, 4'b0001, 0, 3'b0, 0, 6'b0, 1, 0)});
        drain();
        @(negedge clock);
        #1 reset = 1'b1;
        step("rs_after", MRD, 16'h8000, 8'h00, 0, z);
        step("rs_idle",  BI,  16'h0000, 8'h00, 0, z);

        @(negedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
